// File: rtl/sq_ctrl.sv
// Store-queue allocation/retirement controller: dual-slot dispatch allocation,
// in-order commit tracking, dcache write drain and flush of uncommitted entries.
module sq_ctrl #(
  parameter int SQ_SIZE = 8,
  parameter int IDX_W   = $clog2(SQ_SIZE)
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               disp_st1_valid_i,
  input  logic               disp_st2_valid_i,
  input  logic [1:0]         rob_st_commit_cnt_i,
  input  logic               flush_i,
  input  logic [SQ_SIZE-1:0] entry_addr_ready_i,
  input  logic               mem_st_ack_i,
  output logic [SQ_SIZE-1:0] sq_alloc_sel1_o,
  output logic [SQ_SIZE-1:0] sq_alloc_sel2_o,
  output logic               sq_stall_o,
  output logic [SQ_SIZE-1:0] sq_clean_o,
  output logic               mem_st_req_o,
  output logic [IDX_W-1:0]   mem_st_idx_o,
  output logic [IDX_W-1:0]   sq_head_o,
  output logic [IDX_W-1:0]   sq_tail_o,
  output logic [IDX_W:0]     sq_count_o,
  output logic               sq_empty_o
);

  // state | meaning
  // IDLE  | no dcache write outstanding
  // REQ   | write of head entry requested, waiting for ack
  typedef enum logic {IDLE, REQ} wb_state_e;

  localparam int CNT_W = IDX_W + 1;

  wb_state_e            state_q;
  logic                 mem_st_req_q;
  logic [IDX_W-1:0]     mem_st_idx_q;
  logic [IDX_W-1:0]     head_q, head_d;
  logic [IDX_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     committed_q, committed_d;
  logic [SQ_SIZE-1:0]   clean_q, clean_d;

  logic [1:0]           need;
  logic [CNT_W-1:0]     free_slots;
  logic                 stall;
  logic [CNT_W-1:0]     alloc_n;
  logic                 ack_fire;
  logic [CNT_W-1:0]     committed_sum;
  logic [IDX_W-1:0]     kill_start;
  logic [CNT_W-1:0]     kill_n;
  logic [SQ_SIZE-1:0]   flush_mask;
  logic [IDX_W-1:0]     tail_p1;

  assign need          = {1'b0, disp_st1_valid_i} + {1'b0, disp_st2_valid_i};
  assign free_slots    = CNT_W'(SQ_SIZE) - count_q;
  assign stall         = (CNT_W'(need) > free_slots) | flush_i;
  assign alloc_n       = stall ? '0 : CNT_W'(need);
  assign tail_p1       = tail_q + IDX_W'(1);
  assign ack_fire      = (state_q == REQ) & mem_st_ack_i;
  assign committed_sum = committed_q + CNT_W'(rob_st_commit_cnt_i);
  assign kill_start    = head_q + committed_sum[IDX_W-1:0];
  assign kill_n        = count_q - committed_sum;

  assign sq_alloc_sel1_o = (!stall && disp_st1_valid_i) ? (SQ_SIZE'(1) << tail_q) : '0;
  assign sq_alloc_sel2_o = (!stall && disp_st2_valid_i) ?
                           (SQ_SIZE'(1) << (disp_st1_valid_i ? tail_p1 : tail_q)) : '0;
  assign sq_stall_o      = stall;

  // Flushed entries are the occupied ones past the surviving committed prefix.
  always_comb begin
    flush_mask = '0;
    for (int i = 0; i < SQ_SIZE; i++) begin
      flush_mask[i] = ({1'b0, IDX_W'(IDX_W'(i) - kill_start)} < kill_n);
    end
  end

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q + alloc_n[IDX_W-1:0];
    count_d     = count_q + alloc_n;
    committed_d = committed_sum;
    clean_d     = '0;
    if (flush_i) begin
      tail_d  = kill_start;
      count_d = committed_sum;
      clean_d = flush_mask;
    end
    // Retirement stacks on top of either the normal or the flushed values.
    if (ack_fire) begin
      head_d      = head_q + IDX_W'(1);
      count_d     = count_d - CNT_W'(1);
      committed_d = committed_d - CNT_W'(1);
      clean_d     = clean_d | (SQ_SIZE'(1) << head_q);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      committed_q <= '0;
      clean_q     <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      committed_q <= committed_d;
      clean_q     <= clean_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      mem_st_req_q <= 1'b0;
      mem_st_idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if ((committed_q != '0) && entry_addr_ready_i[head_q]) begin
            state_q      <= REQ;
            mem_st_req_q <= 1'b1;
            mem_st_idx_q <= head_q;
          end
        end
        REQ: begin
          if (mem_st_ack_i) begin
            state_q      <= IDLE;
            mem_st_req_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          mem_st_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign sq_clean_o   = clean_q;
  assign mem_st_req_o = mem_st_req_q;
  assign mem_st_idx_o = mem_st_idx_q;
  assign sq_head_o    = head_q;
  assign sq_tail_o    = tail_q;
  assign sq_count_o   = count_q;
  assign sq_empty_o   = (count_q == '0);

endmodule

// File: tb/tb_sq_ctrl.sv
// Directed bench for sq_ctrl: allocation, full/stall, writeback handshake,
// flush cleanup and reset during an outstanding request.
module tb_sq_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       st1, st2, flush, ack;
  logic [1:0] ccnt;
  logic [7:0] ready;
  logic [7:0] sel1, sel2, clean;
  logic       stall, req, empty;
  logic [2:0] idx, head, tail;
  logic [3:0] count;

  int pass_cnt = 0;
  int total_cnt = 0;

  sq_ctrl #(.SQ_SIZE(8)) dut (
    .clock_i(clk_i), .reset_i(rst_i),
    .disp_st1_valid_i(st1), .disp_st2_valid_i(st2),
    .rob_st_commit_cnt_i(ccnt), .flush_i(flush),
    .entry_addr_ready_i(ready), .mem_st_ack_i(ack),
    .sq_alloc_sel1_o(sel1), .sq_alloc_sel2_o(sel2), .sq_stall_o(stall),
    .sq_clean_o(clean), .mem_st_req_o(req), .mem_st_idx_o(idx),
    .sq_head_o(head), .sq_tail_o(tail), .sq_count_o(count), .sq_empty_o(empty)
  );

  always #5 clk_i = ~clk_i;

  // Commits beyond the occupied count are illegal stimulus.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (int'(dut.committed_q) + int'(ccnt) <= int'(count))
        else $error("illegal commit: committed+cnt exceeds count");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    #1;
    total_cnt++; if (head !== 3'd0) $display("FAIL rst_head: got %0d want 0", head); else pass_cnt++;
    total_cnt++; if (tail !== 3'd0) $display("FAIL rst_tail: got %0d want 0", tail); else pass_cnt++;
    total_cnt++; if (count !== 4'd0) $display("FAIL rst_count: got %0d want 0", count); else pass_cnt++;
    total_cnt++; if (empty !== 1'b1) $display("FAIL rst_empty: got %b want 1", empty); else pass_cnt++;
    total_cnt++; if (req !== 1'b0) $display("FAIL rst_req: got %b want 0", req); else pass_cnt++;
    total_cnt++; if (clean !== 8'h00) $display("FAIL rst_clean: got %h want 00", clean); else pass_cnt++;
    total_cnt++; if (stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall); else pass_cnt++;
  endtask

  task automatic test_alloc();
    st1 = 1'b1; st2 = 1'b1;
    #1;
    total_cnt++; if (sel1 !== 8'h01) $display("FAIL alloc_sel1: got %h want 01", sel1); else pass_cnt++;
    total_cnt++; if (sel2 !== 8'h02) $display("FAIL alloc_sel2: got %h want 02", sel2); else pass_cnt++;
    total_cnt++; if (stall !== 1'b0) $display("FAIL alloc_stall: got %b want 0", stall); else pass_cnt++;
    tick();
    st1 = 1'b0; st2 = 1'b0;
    #1;
    total_cnt++; if (tail !== 3'd2) $display("FAIL alloc_tail: got %0d want 2", tail); else pass_cnt++;
    total_cnt++; if (count !== 4'd2) $display("FAIL alloc_count: got %0d want 2", count); else pass_cnt++;
    total_cnt++; if (empty !== 1'b0) $display("FAIL alloc_empty: got %b want 0", empty); else pass_cnt++;
  endtask

  task automatic test_full();
    st1 = 1'b1; st2 = 1'b1;
    tick(); tick();
    st2 = 1'b0;
    tick();
    st2 = 1'b1;
    #1;
    total_cnt++; if (stall !== 1'b1) $display("FAIL full7_stall: got %b want 1", stall); else pass_cnt++;
    total_cnt++; if ({sel1, sel2} !== 16'h0000) $display("FAIL full7_sels: got %h want 0000", {sel1, sel2}); else pass_cnt++;
    tick();
    total_cnt++; if (count !== 4'd7) $display("FAIL full7_count: got %0d want 7", count); else pass_cnt++;
    st2 = 1'b0;
    #1;
    total_cnt++; if (sel1 !== 8'h80) $display("FAIL full7_sel1: got %h want 80", sel1); else pass_cnt++;
    total_cnt++; if (stall !== 1'b0) $display("FAIL full7_st1_stall: got %b want 0", stall); else pass_cnt++;
    tick();
    st1 = 1'b0;
    #1;
    total_cnt++; if (tail !== 3'd0) $display("FAIL full_tail_wrap: got %0d want 0", tail); else pass_cnt++;
    total_cnt++; if (count !== 4'd8) $display("FAIL full_count: got %0d want 8", count); else pass_cnt++;
    st2 = 1'b1;
    #1;
    total_cnt++; if (stall !== 1'b1) $display("FAIL full_stall: got %b want 1", stall); else pass_cnt++;
    total_cnt++; if (sel2 !== 8'h00) $display("FAIL full_sel2: got %h want 00", sel2); else pass_cnt++;
    st2 = 1'b0;
  endtask

  task automatic test_writeback_full();
    ready = 8'h01; ccnt = 2'd1;
    tick();
    ccnt = 2'd0;
    for (int k = 0; k < 6 && req !== 1'b1; k++) tick();
    total_cnt++; if (req !== 1'b1) $display("FAIL wb_req: got %b want 1", req); else pass_cnt++;
    total_cnt++; if (idx !== 3'd0) $display("FAIL wb_idx: got %0d want 0", idx); else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      tick();
      total_cnt++; if ({req, idx} !== 4'b1000) $display("FAIL wb_hold: got req=%b idx=%0d want req=1 idx=0", req, idx); else pass_cnt++;
    end
    ack = 1'b1; st1 = 1'b1;
    #1;
    total_cnt++; if (stall !== 1'b1) $display("FAIL wb_full_stall: got %b want 1", stall); else pass_cnt++;
    total_cnt++; if (sel1 !== 8'h00) $display("FAIL wb_full_sel1: got %h want 00", sel1); else pass_cnt++;
    tick();
    ack = 1'b0;
    #1;
    total_cnt++; if (clean !== 8'h01) $display("FAIL wb_clean: got %h want 01", clean); else pass_cnt++;
    total_cnt++; if (sel1 !== 8'h01) $display("FAIL wb_reuse_sel1: got %h want 01", sel1); else pass_cnt++;
    total_cnt++; if (stall !== 1'b0) $display("FAIL wb_reuse_stall: got %b want 0", stall); else pass_cnt++;
    total_cnt++; if (head !== 3'd1) $display("FAIL wb_head: got %0d want 1", head); else pass_cnt++;
    total_cnt++; if (count !== 4'd7) $display("FAIL wb_count: got %0d want 7", count); else pass_cnt++;
    total_cnt++; if (req !== 1'b0) $display("FAIL wb_req_drop: got %b want 0", req); else pass_cnt++;
    tick();
    st1 = 1'b0;
    #1;
    total_cnt++; if (count !== 4'd8) $display("FAIL wb_refill_count: got %0d want 8", count); else pass_cnt++;
    total_cnt++; if (clean !== 8'h00) $display("FAIL wb_clean_pulse: got %h want 00", clean); else pass_cnt++;
    total_cnt++; if (tail !== 3'd1) $display("FAIL wb_refill_tail: got %0d want 1", tail); else pass_cnt++;
  endtask

  task automatic test_flush();
    rst_i = 1'b1; ready = 8'h00;
    tick();
    rst_i = 1'b0;
    st1 = 1'b1; st2 = 1'b1;
    tick(); tick();
    st1 = 1'b0; st2 = 1'b0;
    ready = 8'h01; ccnt = 2'd1;
    tick();
    ccnt = 2'd0;
    for (int k = 0; k < 6 && req !== 1'b1; k++) tick();
    total_cnt++; if (req !== 1'b1) $display("FAIL fl_req: got %b want 1", req); else pass_cnt++;
    flush = 1'b1; ccnt = 2'd1; st1 = 1'b1;
    #1;
    total_cnt++; if (stall !== 1'b1) $display("FAIL fl_stall: got %b want 1", stall); else pass_cnt++;
    total_cnt++; if (sel1 !== 8'h00) $display("FAIL fl_sel1: got %h want 00", sel1); else pass_cnt++;
    tick();
    flush = 1'b0; ccnt = 2'd0; st1 = 1'b0;
    #1;
    total_cnt++; if (tail !== 3'd2) $display("FAIL fl_tail: got %0d want 2", tail); else pass_cnt++;
    total_cnt++; if (count !== 4'd2) $display("FAIL fl_count: got %0d want 2", count); else pass_cnt++;
    total_cnt++; if (clean !== 8'h0C) $display("FAIL fl_clean: got %h want 0c", clean); else pass_cnt++;
    total_cnt++; if ({req, idx} !== 4'b1000) $display("FAIL fl_req_kept: got req=%b idx=%0d want req=1 idx=0", req, idx); else pass_cnt++;
    tick();
    total_cnt++; if (clean !== 8'h00) $display("FAIL fl_clean_pulse: got %h want 00", clean); else pass_cnt++;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    #1;
    total_cnt++; if (clean !== 8'h01) $display("FAIL fl_ack_clean: got %h want 01", clean); else pass_cnt++;
    total_cnt++; if (head !== 3'd1) $display("FAIL fl_ack_head: got %0d want 1", head); else pass_cnt++;
    total_cnt++; if (count !== 4'd1) $display("FAIL fl_ack_count: got %0d want 1", count); else pass_cnt++;
    total_cnt++; if (req !== 1'b0) $display("FAIL fl_ack_req: got %b want 0", req); else pass_cnt++;
  endtask

  task automatic test_reset_in_req();
    ready = 8'h02;
    for (int k = 0; k < 6 && req !== 1'b1; k++) tick();
    total_cnt++; if ({req, idx} !== 4'b1001) $display("FAIL rr_req: got req=%b idx=%0d want req=1 idx=1", req, idx); else pass_cnt++;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0; ready = 8'h00;
    #1;
    total_cnt++; if (req !== 1'b0) $display("FAIL rr_req_drop: got %b want 0", req); else pass_cnt++;
    total_cnt++; if ({head, tail} !== 6'd0) $display("FAIL rr_ptrs: got head=%0d tail=%0d want 0 0", head, tail); else pass_cnt++;
    total_cnt++; if (count !== 4'd0) $display("FAIL rr_count: got %0d want 0", count); else pass_cnt++;
    total_cnt++; if (empty !== 1'b1) $display("FAIL rr_empty: got %b want 1", empty); else pass_cnt++;
    total_cnt++; if (clean !== 8'h00) $display("FAIL rr_clean: got %h want 00", clean); else pass_cnt++;
  endtask

  initial begin
    rst_i = 1'b1; st1 = 1'b0; st2 = 1'b0; flush = 1'b0; ack = 1'b0;
    ccnt = 2'd0; ready = 8'h00;
    test_reset();
    test_alloc();
    test_full();
    test_writeback_full();
    test_flush();
    test_reset_in_req();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
